// File: rtl/dds_phase_gen.sv
// dds_phase_gen: DDS phase accumulator, quarter-wave table addressing and full-period sample rebuild.
// Optional macro DDS_SYNC_WRAP_EN: apply a loaded config only at accumulator wrap (or while en=0).
`timescale 1ns/1ps
module dds_phase_gen #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] freq_word,
  input  logic [7:0]       phase_off,
  input  logic             cfg_load,
  output logic             cfg_pending,
  output logic [5:0]       tbl_addr,
  input  logic [8:0]       tbl_data,
  output logic [9:0]       wave_out,
  output logic             out_valid,
  output logic             wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fw_sh;
  logic [ACC_W-1:0] fw_act;
  logic [7:0]       po_sh;
  logic [7:0]       po_act;
  logic [ACC_W-1:0] acc_sum;
  logic             acc_carry;
  logic             apply;
  logic [7:0]       idx;
  logic [1:0]       quad;
  logic             en_d;

  assign {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, fw_act};
  assign idx = acc[ACC_W-1 -: 8] + po_act;

`ifdef DDS_SYNC_WRAP_EN
  // Phase-continuous: switch at the carry edge, or whenever stalled so a config is never stranded.
  assign apply = cfg_pending && (!en || acc_carry);
`else
  assign apply = cfg_pending;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fw_sh       <= '0;
      po_sh       <= '0;
      fw_act      <= '0;
      po_act      <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_load) begin
        fw_sh <= freq_word;
        po_sh <= phase_off;
      end
      if (apply) begin
        fw_act <= fw_sh;
        po_act <= po_sh;
      end
      // A load coinciding with an apply keeps the new shadow value pending.
      if (cfg_load)
        cfg_pending <= 1'b1;
      else if (apply)
        cfg_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else begin
      if (en)
        acc <= acc_sum;
      wrap <= en && acc_carry;
    end
  end

  // Quadrants 1 and 3 read the quarter table backwards; quadrants 2 and 3 are negated below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quad      <= 2'd0;
      tbl_addr  <= 6'd0;
      wave_out  <= 10'd512;
      en_d      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      quad      <= idx[7:6];
      tbl_addr  <= idx[6] ? ~idx[5:0] : idx[5:0];
      wave_out  <= quad[1] ? (10'd512 - {1'b0, tbl_data}) : (10'd512 + {1'b0, tbl_data});
      en_d      <= en;
      out_valid <= en_d;
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed self-checking bench for dds_phase_gen with a behavioural quarter table.
// Covers reset, latency, sweep, phase offset, config apply timing (both DDS_SYNC_WRAP_EN builds), async reset.
`timescale 1ns/1ps
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] freq_word;
  logic [7:0]  phase_off;
  logic        cfg_load;
  logic        cfg_pending;
  logic [5:0]  tbl_addr;
  logic [8:0]  tbl_data;
  logic [9:0]  wave_out;
  logic        out_valid;
  logic        wrap;
  logic        square_tbl;
  logic        wrap_seen;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [7:0]  offs [3]      = '{8'h40, 8'h80, 8'hC0};
  logic [5:0]  offs_addr [3] = '{6'd63, 6'd0, 6'd63};
  logic [9:0]  offs_wave [3] = '{10'd1021, 10'd507, 10'd3};

  dds_phase_gen #(.ACC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .freq_word   (freq_word),
    .phase_off   (phase_off),
    .cfg_load    (cfg_load),
    .cfg_pending (cfg_pending),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .wave_out    (wave_out),
    .out_valid   (out_valid),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  // Square table is full-scale everywhere; ramp table makes each address distinguishable.
  assign tbl_data = square_tbl ? 9'h1FF : {tbl_addr, 3'b101};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] fw, input logic [7:0] po);
    cfg_load  = 1'b1;
    freq_word = fw;
    phase_off = po;
    tick(1);
    cfg_load  = 1'b0;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    en       = 1'b0;
    cfg_load = 1'b0;
    tick(2);
    rst      = 1'b0;
  endtask

  function automatic logic [5:0] quarter_addr(input int i);
    int p;
    p = i % 256;
    return ((p / 64) % 2 == 1) ? 6'(63 - (p % 64)) : 6'(p % 64);
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; cfg_load = 1'b0;
    freq_word = '0; phase_off = '0; square_tbl = 1'b0;

    // reset must take effect before any clock edge
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_tbl_addr", tbl_addr, 0);
    checkOutput("rst_wave_out", wave_out, 512);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_wrap", wrap, 0);
    checkOutput("rst_cfg_pending", cfg_pending, 0);
    tick(2);
    rst = 1'b0;

    // first-sample latency with fw_act=0
    en = 1'b1;
    checkOutput("lat_valid_e0", out_valid, 0);
    tick(1);
    checkOutput("lat_valid_e1", out_valid, 0);
    tick(1);
    checkOutput("lat_valid_e2", out_valid, 1);
    checkOutput("lat_wave_first", wave_out, 517);
    wrap_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (wrap !== 1'b0) wrap_seen = 1'b1;
    end
    checkOutput("wrap_fw0", wrap_seen, 0);
    en = 1'b0;

    // stalled apply, then full sweep with square table
    doReset();
    square_tbl = 1'b1;
    applyStimulus(32'h0100_0000, 8'h00);
    checkOutput("stall_pend_set", cfg_pending, 1);
    tick(1);
    checkOutput("stall_pend_clr", cfg_pending, 0);
    en = 1'b1;
    for (int j = 1; j <= 520; j++) begin
      tick(1);
      checkOutput($sformatf("sweep_addr_%0d", j), tbl_addr, quarter_addr(j - 1));
      checkOutput($sformatf("sweep_wrap_%0d", j), wrap, (j % 256 == 0) ? 1 : 0);
      checkOutput($sformatf("sweep_valid_%0d", j), out_valid, (j >= 2) ? 1 : 0);
      if (j >= 2)
        checkOutput($sformatf("sweep_wave_%0d", j), wave_out, (((j - 2) % 256) < 128) ? 1023 : 1);
    end
    en = 1'b0;

    // phase offsets landing in quadrants 1, 2, 3
    for (int k = 0; k < 3; k++) begin
      doReset();
      square_tbl = 1'b0;
      applyStimulus(32'h0100_0000, offs[k]);
      tick(1);
      en = 1'b1;
      tick(1);
      checkOutput($sformatf("poff_addr_%0d", k), tbl_addr, offs_addr[k]);
      tick(1);
      checkOutput($sformatf("poff_valid_%0d", k), out_valid, 1);
      checkOutput($sformatf("poff_wave_%0d", k), wave_out, offs_wave[k]);
      en = 1'b0;
    end

    // config update while running
    doReset();
    square_tbl = 1'b1;
    applyStimulus(32'h0100_0000, 8'h00);
    tick(1);
    en = 1'b1;
    tick(100);
`ifdef DDS_SYNC_WRAP_EN
    applyStimulus(32'h0500_0000, 8'h00);
    tick(20);
    checkOutput("sync_pend_hold", cfg_pending, 1);
    applyStimulus(32'h0200_0000, 8'h00);
    tick(133);
    checkOutput("sync_pend_prewrap", cfg_pending, 1);
    tick(1);
    checkOutput("sync_pend_clr", cfg_pending, 0);
    checkOutput("sync_wrap", wrap, 1);
    tick(1);
    checkOutput("sync_addr_0", tbl_addr, 0);
    tick(1);
    checkOutput("sync_addr_2", tbl_addr, 2);
    tick(1);
    checkOutput("sync_addr_4", tbl_addr, 4);
`else
    applyStimulus(32'h0200_0000, 8'h00);
    applyStimulus(32'h0300_0000, 8'h00);
    checkOutput("imm_pend_overlap", cfg_pending, 1);
    tick(1);
    checkOutput("imm_pend_clr", cfg_pending, 0);
    checkOutput("imm_addr_102", tbl_addr, 25);
    tick(1);
    checkOutput("imm_addr_104", tbl_addr, 23);
    tick(1);
    checkOutput("imm_addr_107", tbl_addr, 20);
`endif
    en = 1'b0;

    // async reset mid-sweep with a config pending
    doReset();
    square_tbl = 1'b1;
    applyStimulus(32'h0100_0000, 8'h00);
    tick(1);
    en = 1'b1;
    tick(50);
    applyStimulus(32'h0200_0000, 8'h00);
    checkOutput("arst_pre_pend", cfg_pending, 1);
    checkOutput("arst_pre_addr", tbl_addr, 50);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_tbl_addr", tbl_addr, 0);
    checkOutput("arst_wave_out", wave_out, 512);
    checkOutput("arst_cfg_pending", cfg_pending, 0);
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_wrap", wrap, 0);
    tick(1);
    rst = 1'b0;
    tick(3);
    checkOutput("arst_post_pend", cfg_pending, 0);
    checkOutput("arst_post_addr", tbl_addr, 0);
    checkOutput("arst_post_wave", wave_out, 1023);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_phase_gen.md
# dds_phase_gen

Phase-accumulator and quarter-wave address generator for the DDS datapath. It takes the frequency and phase words that the SPI slave register file delivers and accumulates phase. It maps each 8-bit phase index (256 points per period) onto the 6-bit address of a quarter-period waveform table. It then rebuilds the full-period 10-bit sample from the table's 9-bit magnitude using quadrant mirroring and sign. It sits directly upstream of the wave tables (sine, square, triangle) and feeds the DAC output register.

## Interface
Parameters:
- ACC_W, 32, phase accumulator width; the phase index is acc[ACC_W-1 -: 8].

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset, asynchronous and active-high.
- en, input, 1, accumulate enable.
- freq_word, input, ACC_W, frequency tuning word. Sampled only on cfg_load.
- phase_off, input, 8, phase offset in table points. Sampled only on cfg_load.
- cfg_load, input, 1, single-cycle strobe from the SPI register file.
- cfg_pending, output, 1, a loaded config is waiting to be applied.
- tbl_addr, output, 6, registered quarter-table address.
- tbl_data, input, 9, combinational table output for tbl_addr.
- wave_out, output, 10, offset-binary sample; the midscale value is 512.
- out_valid, output, 1, wave_out holds a sample taken while en was high.
- wrap, output, 1, one-cycle pulse on accumulator carry-out.

## Operation
- Shadow registers hold fw_sh and po_sh; active registers hold fw_act and po_act. cfg_load copies freq_word/phase_off into the shadow registers and sets cfg_pending.
- Accumulator, when en=1: acc <= acc + fw_act, modulo 2^ACC_W. The carry-out drives wrap on the following cycle, registered. When en=0, acc holds.
- Stage 1, registered:
  - idx = acc[ACC_W-1 -: 8] + po_act, modulo 256.
  - quad <= idx[7:6].
  - tbl_addr <= quad[0] ? ~idx[5:0] : idx[5:0]. Quadrants 1 and 3 are mirrored, so address = 63 - idx[5:0].
- Stage 2, registered:
  - wave_out <= quad_d[1] ? 10'd512 - tbl_data : 10'd512 + tbl_data, where quad_d is quad delayed to match the table read.
  - Range is 1..1023. No overflow is possible.
- The pipeline runs every cycle regardless of en. out_valid is en delayed 2 cycles.
- Apply rule: the active registers are loaded from the shadow registers and cfg_pending clears. When this happens is set in Configuration. A cfg_load while cfg_pending=1 overwrites the shadow registers; the last write wins.
- cfg_load on the same cycle as the apply edge: the shadow registers take the new value, the active registers take the old shadow value, and cfg_pending stays 1.
- Reset values:
  - acc, fw_act, po_act, fw_sh, po_sh = 0.
  - tbl_addr = 0, quad = 0.
  - wave_out = 512.
  - out_valid, wrap, cfg_pending = 0.
- Reset mid-operation clears all state immediately. A pending config is discarded.

## Timing
- Latency from acc value to wave_out: 2 clocks (acc -> tbl_addr -> wave_out).
- First valid sample: en high at edge N gives out_valid=1 after edge N+2.
- An fw_act change affects the acc increment at the first edge after the apply edge.
- wrap is asserted for exactly 1 cycle per carry. With fw_act=0, wrap never occurs.

## Configuration
- DDS_SYNC_WRAP_EN defined (phase-continuous update):
  - The apply happens on the edge where the accumulator carries out, gated by en=1.
  - It also happens on any edge where en=0, so a zero or stalled frequency cannot strand a pending config.
- DDS_SYNC_WRAP_EN undefined:
  - The apply happens on the edge following cfg_load.
  - cfg_pending pulses high for 1 cycle only.
  - The other rules are unchanged.

## Test plan
- Sweep: reset, load freq_word=0x01000000 and phase_off=0, en=1, with a square table (tbl_data=0x1FF for every address).
  - Required tbl_addr sequence: 0..63, then 63..0, repeating.
  - Required wave_out: 1023 for 128 samples, then 1 for 128 samples.
  - Required wrap: one pulse every 256 cycles.
- Latency: on the first cycle with en=1 after reset, out_valid rises exactly 2 edges later, and the first wave_out equals 512+tbl_data(0).
- Phase offset: phase_off=0x40 at freq_word=0x01000000. The first valid sample has quad=1 and tbl_addr=63.
- Sync update (macro defined): at fw=0x01000000, load fw=0x02000000 mid-period.
  - cfg_pending stays high until the wrap edge.
  - After that edge the index steps by 2.
  - A second load before the wrap overwrites the first.
- Stalled apply: with en=0 and fw=0, a cfg_load is applied on the next edge and cfg_pending clears within 2 cycles.
- Async reset: assert rst mid-sweep with a config pending. The reset values appear immediately without a clock, and cfg_pending=0 after release.
